// File: rtl/ws2812_pkg.sv
// Shared types for the WS2812/SK6812 frame controller: pixel layout and frame FSM states.
package ws2812_pkg;

   localparam int PIXEL_W = 24;
   localparam int CH_W    = 8;
   localparam int R_LSB   = 16;
   localparam int G_LSB   = 8;
   localparam int B_LSB   = 0;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } pixel_t;

   typedef enum logic [0:0] {
      FC_IDLE    = 1'b0,
      FC_PENDING = 1'b1
   } fc_state_t;

endpackage

// File: rtl/ws2812_pix_bank.sv
// Two banks of NUM_LEDS pixels: one synchronous write port, one asynchronous read port.
module ws2812_pix_bank
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 4,
   localparam int AW = $clog2(NUM_LEDS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output pixel_t        rd_data
);

   localparam logic [AW:0] LED_LIMIT = (AW+1)'(NUM_LEDS);

   pixel_t mem [2][NUM_LEDS];
   logic   rd_ok;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Non-power-of-two chains leave unused address codes; those read as black.
   assign rd_ok   = ({1'b0, rd_addr} < LED_LIMIT);
   assign rd_data = rd_ok ? mem[rd_bank][rd_addr] : '0;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered frame controller for the WS2812 driver; banks swap only at the frame boundary.
// Optional global brightness scaling is enabled with `define WS2812_BRIGHTNESS_EN.
module ws2812_frame_ctrl
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 4,
   localparam int AW = $clog2(NUM_LEDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data,
   output logic          wr_ready,
   input  logic          commit,
   output logic          commit_pending,
   output logic          wr_error,
   input  logic [7:0]    brightness,
   input  logic          drv_data_request,
   input  logic [AW-1:0] drv_address,
   output logic [7:0]    red_out,
   output logic [7:0]    green_out,
   output logic [7:0]    blue_out,
   output logic          frame_start,
   output logic [15:0]   frame_count
);

   localparam logic [AW:0] LED_LIMIT = (AW+1)'(NUM_LEDS);

   fc_state_t state;
   logic      display_bank;
   logic      display_valid;
   logic      idle;
   logic      addr_ok;
   logic      wr_accept;
   logic      wr_drop;
   logic      commit_accept;
   logic      boundary;
   logic      swap;
   logic      rd_bank;
   logic      valid_now;
   pixel_t    rd_pix;
   pixel_t    shown_pix;
   pixel_t    pix_p1;

`ifdef WS2812_BRIGHTNESS_EN
   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = {8'd0, c} * ({8'd0, b} + 16'd1);
      return 8'(prod >> 8);
   endfunction
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
`endif

   assign idle          = (state == FC_IDLE);
   assign addr_ok       = ({1'b0, wr_addr} < LED_LIMIT);
   assign wr_accept     = wr_en & idle & addr_ok;
   assign wr_drop       = wr_en & ~wr_accept;
   assign commit_accept = commit & idle;
   assign boundary      = drv_data_request & (drv_address == '0);
   // A commit arriving together with the boundary still makes this frame.
   assign swap          = boundary & (~idle | commit_accept);
   assign rd_bank       = display_bank ^ swap;
   assign valid_now     = display_valid | swap;

   ws2812_pix_bank #(
      .NUM_LEDS (NUM_LEDS)
   ) u_bank (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_bank (~display_bank),
      .wr_addr (wr_addr),
      .wr_data (pixel_t'(wr_data)),
      .rd_bank (rd_bank),
      .rd_addr (drv_address),
      .rd_data (rd_pix)
   );

   always_comb begin
      shown_pix = '0;
      if (valid_now) begin
`ifdef WS2812_BRIGHTNESS_EN
         shown_pix.r = scale_ch(rd_pix.r, brightness);
         shown_pix.g = scale_ch(rd_pix.g, brightness);
         shown_pix.b = scale_ch(rd_pix.b, brightness);
`else
         shown_pix = rd_pix;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= FC_IDLE;
         display_bank  <= 1'b0;
         display_valid <= 1'b0;
         wr_error      <= 1'b0;
         frame_start   <= 1'b0;
         frame_count   <= 16'd0;
      end else begin
         frame_start <= swap;
         if (swap) begin
            state         <= FC_IDLE;
            display_bank  <= ~display_bank;
            display_valid <= 1'b1;
            frame_count   <= frame_count + 16'd1;
         end else if (commit_accept) begin
            state <= FC_PENDING;
         end
         if (commit_accept) begin
            wr_error <= 1'b0;
         end else if (wr_drop) begin
            wr_error <= 1'b1;
         end
      end
   end

   // Output stage: the driver samples one cycle after its request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_p1 <= '0;
      end else if (drv_data_request) begin
         pix_p1 <= shown_pix;
      end
   end

   assign wr_ready       = idle;
   assign commit_pending = ~idle;
   assign red_out        = pix_p1.r;
   assign green_out      = pix_p1.g;
   assign blue_out       = pix_p1.b;

endmodule
